// File: rtl/pio_pkg.sv
// Shared definitions for the bidirectional PIO block: register offsets,
// edge-type encodings and the edge-detect helper.
package pio_pkg;

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_MASK    = 3'd2,
    REG_CAPTURE = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } pio_reg_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge flags between the current and previous sampled pin values.
  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int          edge_type);
    logic [31:0] e;
    case (edge_type)
      EDGE_FALL: e = ~cur & prev;
      EDGE_ANY:  e = cur ^ prev;
      default:   e = cur & ~prev;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pio_sync.sv
// Multi-stage synchroniser for the asynchronous PIO pin inputs.
module pio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];

  // Shift the raw pins through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/pio_bidir_irq.sv
// Bidirectional PIO with Avalon-MM register interface, edge capture and
// level interrupt.
module pio_bidir_irq
  import pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  // Capture stays off until the synchroniser and delay flop hold real pin data.
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_dly;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      edge_all;
  logic [31:0]      rd_mux;
  logic [2:0]       warm_cnt;
  logic             warm_done;
  logic             wr_en;
  pio_reg_e         reg_sel;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign reg_sel   = pio_reg_e'(address);
  assign warm_done = (warm_cnt == WARM_LAST);

  pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_in)
  );

  // One extra delay of the synchronised pins for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_dly <= '0;
    else          sync_dly <= sync_in;
  end

  // Warm-up counter after reset release; saturates once capture is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
  end

  // Edges only count on input bits, and only after warm-up.
  assign edge_all = edge_detect(32'(sync_in), 32'(sync_dly), EDGE_TYPE);
  assign cap_set  = edge_all[WIDTH-1:0] & ~direction & {WIDTH{warm_done}};
  assign cap_clr  = (wr_en && reg_sel == REG_CAPTURE) ? wd : '0;

  // Sticky capture bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~cap_clr) | cap_set;
  end

  // Register writes for data, direction, mask and the set/clear aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE[WIDTH-1:0];
      direction <= DIR_RESET[WIDTH-1:0];
      irq_mask  <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DATA:   data_out  <= wd;
        REG_DIR:    direction <= wd;
        REG_MASK:   irq_mask  <= wd;
        REG_OUTSET: data_out  <= data_out | wd;
        REG_OUTCLR: data_out  <= data_out & ~wd;
        default:    ;
      endcase
    end
  end

  // Read mux from the current address; pins read back per direction bit.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:    rd_mux[WIDTH-1:0] = (data_out & direction) | (sync_in & ~direction);
      REG_DIR:     rd_mux[WIDTH-1:0] = direction;
      REG_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
      REG_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle behind the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign out_port = data_out;
  assign out_oe   = direction;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Self-checking bench for pio_bidir_irq: two configurations share one bus
// and are compared each cycle against a pin-history reference model.
module tb_pio_bidir_irq;

  localparam int          W   = 8;
  localparam int          SS0 = 2;
  localparam int          SS1 = 3;
  localparam int          ET0 = 0;
  localparam int          ET1 = 2;
  localparam logic [31:0] RV0 = 32'hA5;
  localparam logic [31:0] RV1 = 32'h00;
  localparam logic [31:0] DR0 = 32'hFF;
  localparam logic [31:0] DR1 = 32'h00;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd1;
  logic [W-1:0]  op0, op1, oe0, oe1;
  logic          irq0, irq1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  m_out  [2];
  logic [W-1:0]  m_dir  [2];
  logic [W-1:0]  m_mask [2];
  logic [W-1:0]  m_cap  [2];
  logic [31:0]   m_rd   [2];
  logic [W-1:0]  hist   [$];
  int            edge_n;

  always #5 clk = ~clk;

  pio_bidir_irq #(
    .WIDTH(W), .RESET_VALUE(RV0), .DIR_RESET(DR0), .EDGE_TYPE(ET0), .SYNC_STAGES(SS0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
    .out_port(op0), .out_oe(oe0), .irq(irq0)
  );

  pio_bidir_irq #(
    .WIDTH(W), .RESET_VALUE(RV1), .DIR_RESET(DR1), .EDGE_TYPE(ET1), .SYNC_STAGES(SS1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port),
    .out_port(op1), .out_oe(oe1), .irq(irq1)
  );

  function automatic int ss_of(int i);
    return (i == 0) ? SS0 : SS1;
  endfunction

  function automatic int et_of(int i);
    return (i == 0) ? ET0 : ET1;
  endfunction

  // Pin value sampled at clock edge k after reset release (0 before any edge).
  function automatic logic [W-1:0] pin_at(int k);
    if (k < 1 || k > hist.size()) return '0;
    return hist[k-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out[0] = RV0[W-1:0]; m_dir[0] = DR0[W-1:0];
    m_out[1] = RV1[W-1:0]; m_dir[1] = DR1[W-1:0];
    for (int i = 0; i < 2; i++) begin
      m_mask[i] = '0; m_cap[i] = '0; m_rd[i] = '0;
    end
    hist.delete();
    edge_n = 0;
  endtask

  // Effect of one rising clock edge with the inputs currently applied.
  task automatic model_edge();
    logic [W-1:0] nv, ov, ed, set, clr, wd;
    logic         wr;
    edge_n++;
    hist.push_back(in_port);
    wr = chipselect && !write_n;
    wd = writedata[W-1:0];
    for (int i = 0; i < 2; i++) begin
      nv = pin_at(edge_n - ss_of(i));
      ov = pin_at(edge_n - ss_of(i) - 1);
      case (address)
        3'd0:    m_rd[i] = {24'h0, (m_out[i] & m_dir[i]) | (nv & ~m_dir[i])};
        3'd1:    m_rd[i] = {24'h0, m_dir[i]};
        3'd2:    m_rd[i] = {24'h0, m_mask[i]};
        3'd3:    m_rd[i] = {24'h0, m_cap[i]};
        default: m_rd[i] = 32'h0;
      endcase
      case (et_of(i))
        1:       ed = ~nv & ov;
        2:       ed = nv ^ ov;
        default: ed = nv & ~ov;
      endcase
      set = (edge_n >= ss_of(i) + 2) ? (ed & ~m_dir[i]) : '0;
      clr = (wr && address == 3'd3) ? wd : '0;
      m_cap[i] = (m_cap[i] & ~clr) | set;
      if (wr) begin
        case (address)
          3'd0: m_out[i]  = wd;
          3'd1: m_dir[i]  = wd;
          3'd2: m_mask[i] = wd;
          3'd4: m_out[i]  = m_out[i] | wd;
          3'd5: m_out[i]  = m_out[i] & ~wd;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    chk("rd0",   rd0,  m_rd[0]);
    chk("out0",  op0,  m_out[0]);
    chk("oe0",   oe0,  m_dir[0]);
    chk("irq0",  irq0, |(m_cap[0] & m_mask[0]));
    chk("rd1",   rd1,  m_rd[1]);
    chk("out1",  op1,  m_out[1]);
    chk("oe1",   oe1,  m_dir[1]);
    chk("irq1",  irq1, |(m_cap[1] & m_mask[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_addr(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    model_reset();

    // Reset state of both configurations.
    #12;
    chk("rst_out0", op0, 32'hA5);
    chk("rst_oe0",  oe0, 32'hFF);
    chk("rst_rd0",  rd0, 32'h0);
    chk("rst_irq0", irq0, 32'h0);
    chk("rst_out1", op1, 32'h00);
    chk("rst_oe1",  oe1, 32'h00);
    chk("rst_irq1", irq1, 32'h0);
    reset_n = 1'b1;

    // Pins high through reset release must not capture.
    wr(3'd2, 32'hFF);
    idle(6);
    rd_addr(3'd3);
    chk("warm_cap1", rd1, 32'h0);
    chk("warm_irq1", irq1, 32'h0);

    // Data, outset, outclear.
    wr(3'd0, 32'h0F); chk("data_wr", op0, 32'h0F);
    wr(3'd4, 32'h30); chk("outset",  op0, 32'h3F);
    wr(3'd5, 32'h03); chk("outclr",  op0, 32'h3C);

    // Mixed-direction readback of the data register.
    wr(3'd1, 32'hF0);
    wr(3'd0, 32'hA0);
    in_port = 8'h05;
    idle(4);
    rd_addr(3'd0);
    chk("mixed_rd", rd0, 32'h000000A5);

    // Rising edge capture latency, interrupt and write-1-to-clear.
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h01);
    in_port = 8'h00;
    idle(5);
    wr(3'd3, 32'hFF);
    in_port = 8'h01;
    tick(); chk("lat_c1", irq0, 32'h0);
    tick(); chk("lat_c2", irq0, 32'h0);
    tick(); chk("lat_c3", irq0, 32'h1);
    wr(3'd3, 32'h01);
    chk("w1c_irq", irq0, 32'h0);

    // Edge landing on the same cycle as its clear: set wins.
    in_port = 8'h00;
    idle(5);
    wr(3'd3, 32'hFF);
    in_port = 8'h01;
    tick(); tick();
    wr(3'd3, 32'h01);
    chk("setwin_irq", irq0, 32'h1);
    rd_addr(3'd3);
    chk("setwin_cap", rd0 & 32'h1, 32'h1);
    chk("setwin_irq2", irq0, 32'h1);

    // Turning outputs back into inputs does not capture.
    wr(3'd1, 32'hFF);
    in_port = 8'h00;
    idle(5);
    wr(3'd3, 32'hFF);
    wr(3'd1, 32'h00);
    idle(5);
    rd_addr(3'd3);
    chk("dirchg_cap0", rd0, 32'h0);
    chk("dirchg_cap1", rd1, 32'h0);

    // Reset asserted while a write is pending.
    address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h5A;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_out0", op0, 32'hA5);
    chk("abort_oe0",  oe0, 32'hFF);
    chk("abort_rd0",  rd0, 32'h0);
    @(posedge clk);
    #3;
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    idle(2);
    chk("abort_post", op0, 32'hA5);

    // Randomised bus traffic and pin activity.
    repeat (400) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
